// File: rtl/ifft_r2_butterfly_stage.sv
// rtl/ifft_r2_butterfly_stage.sv - one radix-2 DIF butterfly stage of the 32-point IFFT
// x = sat(a+b), y = (a-b)*W^-n, two-register valid/ready pipeline with a pair counter.
module ifft_r2_butterfly_stage #(
    parameter int STAGE = 0,
    parameter int DW    = 15,
    parameter int TW    = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_first,
    input  logic [DW-1:0] a_re,
    input  logic [DW-1:0] a_im,
    input  logic [DW-1:0] b_re,
    input  logic [DW-1:0] b_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [DW-1:0] x_re,
    output logic [DW-1:0] x_im,
    output logic [DW-1:0] y_re,
    output logic [DW-1:0] y_im
);

    localparam logic [3:0] N_MASK = 4'((16 >> STAGE) - 1);

    function automatic logic [DW-1:0] sat(input logic [DW:0] v);
        if (v[DW] != v[DW-1])
            sat = v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            sat = v[DW-1:0];
    endfunction

    function automatic logic [DW:0] sext(input logic [DW-1:0] v);
        sext = {v[DW-1], v};
    endfunction

    logic          adv;
    logic          take;
    logic [3:0]    k;
    logic [3:0]    k_used;
    logic [3:0]    n;
    int            cos_i;
    int            sin_i;

    // stage-1 registers
    logic          v1;
    logic          last1;
    logic [DW-1:0] s_re, s_im;
    logic signed [DW-1:0] d_re, d_im;
    logic signed [TW-1:0] c1, s1;

    // stage-2 combinational math
    logic signed [DW+TW-1:0] p_rc, p_is, p_rs, p_ic;
    logic [DW-1:0] t_rc, t_is, t_rs, t_ic;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign take     = in_valid & adv;
    assign k_used   = in_first ? 4'd0 : k;
    assign n        = (k_used & N_MASK) << STAGE;

    // W^-n for the inverse transform: (cos, +sin) of 2*pi*n/32, S1.10
    always_comb begin
        cos_i = 1024;
        sin_i = 0;
        case (n)
            4'd0:  begin cos_i =  1024; sin_i =    0; end
            4'd1:  begin cos_i =  1004; sin_i =  200; end
            4'd2:  begin cos_i =   946; sin_i =  392; end
            4'd3:  begin cos_i =   851; sin_i =  569; end
            4'd4:  begin cos_i =   724; sin_i =  724; end
            4'd5:  begin cos_i =   569; sin_i =  851; end
            4'd6:  begin cos_i =   392; sin_i =  946; end
            4'd7:  begin cos_i =   200; sin_i = 1004; end
            4'd8:  begin cos_i =     0; sin_i = 1024; end
            4'd9:  begin cos_i =  -200; sin_i = 1004; end
            4'd10: begin cos_i =  -392; sin_i =  946; end
            4'd11: begin cos_i =  -569; sin_i =  851; end
            4'd12: begin cos_i =  -724; sin_i =  724; end
            4'd13: begin cos_i =  -851; sin_i =  569; end
            4'd14: begin cos_i =  -946; sin_i =  392; end
            4'd15: begin cos_i = -1004; sin_i =  200; end
            default: begin cos_i = 1024; sin_i = 0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            k <= 4'd0;
        else if (take)
            k <= k_used + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            s_re  <= '0;
            s_im  <= '0;
            d_re  <= '0;
            d_im  <= '0;
            c1    <= '0;
            s1    <= '0;
        end else if (adv) begin
            v1    <= in_valid;
            last1 <= (k_used == 4'd15);
            s_re  <= sat(sext(a_re) + sext(b_re));
            s_im  <= sat(sext(a_im) + sext(b_im));
            d_re  <= sat(sext(a_re) - sext(b_re));
            d_im  <= sat(sext(a_im) - sext(b_im));
            c1    <= TW'(cos_i);
            s1    <= TW'(sin_i);
        end
    end

    // products are floored back to S5.9 by an arithmetic shift over the twiddle fraction
    assign p_rc = d_re * c1;
    assign p_is = d_im * s1;
    assign p_rs = d_re * s1;
    assign p_ic = d_im * c1;
    assign t_rc = DW'(p_rc >>> (TW - 2));
    assign t_is = DW'(p_is >>> (TW - 2));
    assign t_rs = DW'(p_rs >>> (TW - 2));
    assign t_ic = DW'(p_ic >>> (TW - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            x_re      <= '0;
            x_im      <= '0;
            y_re      <= '0;
            y_im      <= '0;
        end else if (adv) begin
            out_valid <= v1;
            out_last  <= last1;
            x_re      <= s_re;
            x_im      <= s_im;
            y_re      <= sat(sext(t_rc) - sext(t_is));
            y_im      <= sat(sext(t_rs) + sext(t_ic));
        end
    end

endmodule

// File: tb/tb_ifft_r2_butterfly_stage.sv
// tb/tb_ifft_r2_butterfly_stage.sv - directed bench for ifft_r2_butterfly_stage
// Two instances (STAGE=0 and STAGE=4) share inputs and handshake.
module tb_ifft_r2_butterfly_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_first, out_ready;
    logic [14:0] a_re, a_im, b_re, b_im;

    logic        rdy0, ov0, ol0;
    logic [14:0] x0r, x0i, y0r, y0i;
    logic        rdy4, ov4, ol4;
    logic [14:0] x4r, x4i, y4r, y4i;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ifft_r2_butterfly_stage #(.STAGE(0), .DW(15), .TW(12)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_first(in_first),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(ov0), .out_ready(out_ready), .out_last(ol0),
        .x_re(x0r), .x_im(x0i), .y_re(y0r), .y_im(y0i)
    );

    ifft_r2_butterfly_stage #(.STAGE(4), .DW(15), .TW(12)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .in_first(in_first),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(ov4), .out_ready(out_ready), .out_last(ol4),
        .x_re(x4r), .x_im(x4i), .y_re(y4r), .y_im(y4i)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one pair in, wait for it at the output of dut0 (and dut4 in lockstep)
    task automatic pair(input string tag, input int ar, input int ai, input int br, input int bi,
                        input logic first, input int exr, input int exi, input int eyr,
                        input int eyi, input logic el, input logic use4);
        int n;
        @(negedge clk);
        a_re = 15'(ar); a_im = 15'(ai); b_re = 15'(br); b_im = 15'(bi);
        in_first = first;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        n = 0;
        while (!ov0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, 1);
        chk({tag, " out_valid"}, 32'(ov0), 1);
        chk({tag, " x_re"}, $signed(x0r), exr);
        chk({tag, " x_im"}, $signed(x0i), exi);
        chk({tag, " out_last"}, 32'(ol0), 32'(el));
        if (use4) begin
            chk({tag, " s4 y_re"}, $signed(y4r), eyr);
            chk({tag, " s4 y_im"}, $signed(y4i), eyi);
        end else begin
            chk({tag, " y_re"}, $signed(y0r), eyr);
            chk({tag, " y_im"}, $signed(y0i), eyi);
        end
    endtask

    initial begin
        logic [3:0]  pat;
        logic        prev_stall;
        logic [14:0] hold_x;
        int          sent, got, cyc;

        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        repeat (2) @(negedge clk);
        chk("rst out_valid", 32'(ov0), 0);
        chk("rst out_last", 32'(ol0), 0);
        chk("rst x_re", $signed(x0r), 0);
        chk("rst y_im", $signed(y0i), 0);
        out_ready = 1'b0;
        #1 chk("rst in_ready", 32'(rdy0), 1);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // T1: k=0, W=1
        pair("T1", 512, 0, 256, 0, 1'b1, 768, 0, 256, 0, 1'b0, 1'b0);
        // T2: k=1..3 fillers, k=4 -> (362,362), k=5..7 fillers, k=8 -> (0,512)
        for (int i = 1; i < 4; i++) pair("T2 fill", 100, 100, 100, 100, 1'b0, 200, 200, 0, 0, 1'b0, 1'b0);
        pair("T2 k4", 512, 0, 0, 0, 1'b0, 512, 0, 362, 362, 1'b0, 1'b0);
        for (int i = 5; i < 8; i++) pair("T2 fill", 100, 100, 100, 100, 1'b0, 200, 200, 0, 0, 1'b0, 1'b0);
        pair("T2 k8", 512, 0, 0, 0, 1'b0, 512, 0, 0, 512, 1'b0, 1'b0);
        // T3: saturation of sum and difference
        pair("T3", 16383, -16384, 16383, 16383, 1'b1, 16383, -1, 0, -16384, 1'b0, 1'b0);
        // T4: floor of -724/1024 at k=4
        pair("T4 fill", 100, 100, 100, 100, 1'b1, 200, 200, 0, 0, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) pair("T4 fill", 100, 100, 100, 100, 1'b0, 200, 200, 0, 0, 1'b0, 1'b0);
        pair("T4 k4", 0, 0, 1, 0, 1'b0, 1, 0, -1, -1, 1'b0, 1'b0);

        // T5: 16-pair frame under out_ready pattern 1,0,0,1
        pat = 4'b1001;
        prev_stall = 1'b0;
        hold_x = '0;
        sent = 0;
        got = 0;
        for (cyc = 0; cyc < 200 && got < 16; cyc++) begin
            @(negedge clk);
            out_ready = pat[cyc % 4];
            if (sent < 16) begin
                a_re = 15'(sent * 100); a_im = 15'(-sent * 50);
                b_re = 15'(sent * 100); b_im = 15'(-sent * 50);
                in_first = (sent == 0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
                in_first = 1'b0;
            end
            #1;
            if (prev_stall) begin
                chk("T5 hold valid", 32'(ov0), 1);
                chk("T5 hold x_re", $signed(x0r), $signed(hold_x));
            end
            prev_stall = ov0 && !out_ready;
            hold_x = x0r;
            if (ov0 && out_ready) begin
                chk("T5 x_re", $signed(x0r), got * 200);
                chk("T5 x_im", $signed(x0i), -got * 100);
                chk("T5 y_re", $signed(y0r), 0);
                chk("T5 last", 32'(ol0), 32'(got == 15));
                got++;
            end
            if (in_valid && rdy0) sent++;
        end
        chk("T5 count", got, 16);
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // T6: STAGE=4 uses n=0 for every k, so y = a-b
        pair("T6 k0", 1000, -200, 300, 500, 1'b1, 1300, 300, 700, -700, 1'b0, 1'b1);
        for (int i = 1; i < 4; i++) pair("T6 k", 1000, -200, 300, 500, 1'b0, 1300, 300, 700, -700, 1'b0, 1'b1);
        // pair in flight in stage 1 when reset hits
        @(negedge clk);
        a_re = 15'(512); a_im = '0; b_re = '0; b_im = '0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("T6 rst out_valid s0", 32'(ov0), 0);
        chk("T6 rst out_valid s4", 32'(ov4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        // k restarts at 0 without in_first: W=1 so y=(512,0)
        pair("T6 post-rst", 512, 0, 0, 0, 1'b0, 512, 0, 512, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
